// File: rtl/board_referee_if.sv
`default_nettype none
// ============================================================================
// Module   : board_referee_if
// Purpose  : Move strobes from game_ctrl and board/result outputs of the referee.
// Revision : 1.0 - initial release
// ============================================================================
interface board_referee_if;
    logic       new_game;
    logic       move_P1_i;
    logic [3:0] move_P1;
    logic       move_P2_i;
    logic [3:0] move_P2;
    logic       illegal_move;
    logic [8:0] board_P1;
    logic [8:0] board_P2;
    logic       turn;
    logic       game_over;
    logic [1:0] winner;
    logic [8:0] win_line;
    logic       timeout;

    modport master (
        output new_game, move_P1_i, move_P1, move_P2_i, move_P2,
        input  illegal_move, board_P1, board_P2, turn, game_over, winner, win_line, timeout
    );

    modport slave (
        input  new_game, move_P1_i, move_P1, move_P2_i, move_P2,
        output illegal_move, board_P1, board_P2, turn, game_over, winner, win_line, timeout
    );
endinterface
`default_nettype wire

// File: rtl/board_referee.sv
`default_nettype none
// ============================================================================
// Module   : board_referee
// Purpose  : Tic-tac-toe rule engine: validates moves, alternates turns, detects
//            win/draw. Optional per-turn forfeit timer under MOVE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_referee #(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int TMR_W          = 29
) (
    input wire logic        clk,
    input wire logic        reset_n,
    board_referee_if.slave  bus
);

    localparam logic [1:0] c_WAIT_P1 = 2'd0;
    localparam logic [1:0] c_WAIT_P2 = 2'd1;
    localparam logic [1:0] c_EVAL    = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam logic [8:0] c_LINES [8] = '{
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    logic [1:0] r_state;
    logic [8:0] r_board_p1;
    logic [8:0] r_board_p2;
    logic [8:0] r_win_line;
    logic [1:0] r_winner;
    logic       r_turn;
    logic       r_game_over;
    logic       r_illegal;

    logic       w_in_wait;
    logic       w_p2_turn;
    logic       w_exp_stb;
    logic       w_oth_stb;
    logic [3:0] w_idx;
    logic [8:0] w_mask;
    logic       w_legal;
    logic [8:0] w_mover;
    logic [7:0] w_hit;
    logic [8:0] w_win_line;
    logic       w_full;
    logic       w_expire;

    assign w_in_wait = (r_state == c_WAIT_P1) || (r_state == c_WAIT_P2);
    assign w_p2_turn = (r_state == c_WAIT_P2);
    assign w_exp_stb = w_p2_turn ? bus.move_P2_i : bus.move_P1_i;
    assign w_oth_stb = w_p2_turn ? bus.move_P1_i : bus.move_P2_i;
    assign w_idx     = w_p2_turn ? bus.move_P2   : bus.move_P1;
    // An out-of-range index yields an empty mask, which the legality test rejects.
    assign w_mask    = (w_idx <= 4'd8) ? (9'd1 << w_idx) : 9'd0;
    assign w_legal   = w_in_wait && w_exp_stb && (w_mask != 9'd0)
                       && ((w_mask & (r_board_p1 | r_board_p2)) == 9'd0);

    // Only the player who just moved can have completed a line.
    assign w_mover = r_turn ? r_board_p2 : r_board_p1;
    assign w_full  = &(r_board_p1 | r_board_p2);

    for (genvar g = 0; g < 8; g++) begin : g_line
        assign w_hit[g] = ((w_mover & c_LINES[g]) == c_LINES[g]);
    end

    always_comb begin
        w_win_line = 9'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_hit[i]) w_win_line = w_win_line | c_LINES[i];
        end
    end

`ifdef MOVE_TIMEOUT_EN
    logic [TMR_W-1:0] r_tmr;
    logic             r_timeout;

    assign w_expire = w_in_wait && !w_legal && (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside WAIT so every new turn starts a fresh count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= !bus.new_game && w_expire;
            if (bus.new_game || !w_in_wait || w_legal || w_expire) r_tmr <= '0;
            else                                                   r_tmr <= r_tmr + 1'b1;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{TIMEOUT_CYCLES, TMR_W};
    assign w_expire     = 1'b0;
    assign bus.timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_WAIT_P1;
            r_board_p1  <= 9'd0;
            r_board_p2  <= 9'd0;
            r_win_line  <= 9'd0;
            r_winner    <= 2'b00;
            r_turn      <= 1'b0;
            r_game_over <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            if (bus.new_game) begin
                r_state     <= c_WAIT_P1;
                r_board_p1  <= 9'd0;
                r_board_p2  <= 9'd0;
                r_win_line  <= 9'd0;
                r_winner    <= 2'b00;
                r_turn      <= 1'b0;
                r_game_over <= 1'b0;
            end else begin
                case (r_state)
                    c_WAIT_P1, c_WAIT_P2: begin
                        if (w_legal) begin
                            if (w_p2_turn) r_board_p2 <= r_board_p2 | w_mask;
                            else           r_board_p1 <= r_board_p1 | w_mask;
                            r_state <= c_EVAL;
                        end else begin
                            r_illegal <= w_exp_stb || w_oth_stb;
                            if (w_expire) begin
                                r_turn  <= ~r_turn;
                                r_state <= w_p2_turn ? c_WAIT_P1 : c_WAIT_P2;
                            end
                        end
                    end
                    c_EVAL: begin
                        r_illegal <= bus.move_P1_i || bus.move_P2_i;
                        if (w_win_line != 9'd0) begin
                            r_winner    <= r_turn ? 2'b10 : 2'b01;
                            r_win_line  <= w_win_line;
                            r_game_over <= 1'b1;
                            r_state     <= c_DONE;
                        end else if (w_full) begin
                            r_winner    <= 2'b11;
                            r_game_over <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_turn  <= ~r_turn;
                            r_state <= r_turn ? c_WAIT_P1 : c_WAIT_P2;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.illegal_move = r_illegal;
    assign bus.board_P1     = r_board_p1;
    assign bus.board_P2     = r_board_p2;
    assign bus.turn         = r_turn;
    assign bus.game_over    = r_game_over;
    assign bus.winner       = r_winner;
    assign bus.win_line     = r_win_line;

endmodule
`default_nettype wire

// File: tb/tb_board_referee.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_referee
// Purpose  : Self-checking bench for board_referee: directed vector table,
//            hand sequences and randomized play against a cell-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_referee;

    localparam int c_TO = 16;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    board_referee_if bus();

    board_referee #(.TIMEOUT_CYCLES(c_TO), .TMR_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p1s, p1c, p2s, p2c, ng;
        int bp1, bp2, trn, ovr, win, wl, ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(int p1s, int p1c, int p2s, int p2c, int ng,
                               int bp1, int bp2, int trn, int ovr, int win, int wl, int ill);
        vec_t v;
        v.p1s = p1s; v.p1c = p1c; v.p2s = p2s; v.p2c = p2c; v.ng = ng;
        v.bp1 = bp1; v.bp2 = bp2; v.trn = trn; v.ovr = ovr; v.win = win; v.wl = wl; v.ill = ill;
        return v;
    endfunction

    function automatic vec_t I(int bp1, int bp2, int trn, int ovr, int win, int wl, int ill);
        return V(0, 0, 0, 0, 0, bp1, bp2, trn, ovr, win, wl, ill);
    endfunction

    // Reference model: cell owner array (0 empty, 1 P1, 2 P2) plus game phase flags.
    int       m_cell [9];
    int       m_turn, m_winner, m_tmr;
    bit       m_eval, m_done, m_ill, m_to;
    logic [8:0] m_wl;
    int       lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic model_clear();
        foreach (m_cell[k]) m_cell[k] = 0;
        m_turn = 0; m_winner = 0; m_tmr = 0;
        m_eval = 0; m_done = 0; m_ill = 0; m_to = 0; m_wl = '0;
    endtask

    function automatic logic [8:0] m_board(int who);
        logic [8:0] b = '0;
        for (int k = 0; k < 9; k++) if (m_cell[k] == who) b[k] = 1'b1;
        return b;
    endfunction

    task automatic model_step(bit p1s, int p1c, bit p2s, int p2c, bit ng);
        m_ill = 0; m_to = 0;
        if (ng) begin
            model_clear();
        end else if (m_done) begin
        end else if (m_eval) begin
            int mover = m_turn + 1;
            int filled = 0;
            logic [8:0] wl = '0;
            m_ill = p1s || p2s;
            foreach (lines[l]) begin
                if (m_cell[lines[l][0]] == mover && m_cell[lines[l][1]] == mover &&
                    m_cell[lines[l][2]] == mover) begin
                    for (int j = 0; j < 3; j++) wl[lines[l][j]] = 1'b1;
                end
            end
            for (int k = 0; k < 9; k++) if (m_cell[k] != 0) filled++;
            if (wl != 0) begin
                m_winner = mover; m_wl = wl; m_done = 1;
            end else if (filled == 9) begin
                m_winner = 3; m_done = 1;
            end else begin
                m_turn = 1 - m_turn;
            end
            m_eval = 0; m_tmr = 0;
        end else begin
            bit es = (m_turn == 1) ? p2s : p1s;
            bit os = (m_turn == 1) ? p1s : p2s;
            int c  = (m_turn == 1) ? p2c : p1c;
            if (es && c <= 8 && m_cell[c] == 0) begin
                m_cell[c] = m_turn + 1;
                m_eval = 1;
            end else begin
                m_ill = es || os;
`ifdef MOVE_TIMEOUT_EN
                if (m_tmr == c_TO - 1) begin
                    m_to = 1; m_turn = 1 - m_turn; m_tmr = 0;
                end else begin
                    m_tmr++;
                end
`endif
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, " board_P1"},  32'(bus.board_P1),     32'(m_board(1)));
        chk({tag, " board_P2"},  32'(bus.board_P2),     32'(m_board(2)));
        chk({tag, " turn"},      32'(bus.turn),         32'(m_turn));
        chk({tag, " game_over"}, 32'(bus.game_over),    32'(m_done));
        chk({tag, " winner"},    32'(bus.winner),       32'(m_winner));
        chk({tag, " win_line"},  32'(bus.win_line),     32'(m_wl));
        chk({tag, " illegal"},   32'(bus.illegal_move), 32'(m_ill));
        chk({tag, " timeout"},   32'(bus.timeout),      32'(m_to));
    endtask

    task automatic check_zero(string tag);
        chk({tag, " board_P1"},  32'(bus.board_P1),     0);
        chk({tag, " board_P2"},  32'(bus.board_P2),     0);
        chk({tag, " turn"},      32'(bus.turn),         0);
        chk({tag, " game_over"}, 32'(bus.game_over),    0);
        chk({tag, " winner"},    32'(bus.winner),       0);
        chk({tag, " win_line"},  32'(bus.win_line),     0);
        chk({tag, " illegal"},   32'(bus.illegal_move), 0);
        chk({tag, " timeout"},   32'(bus.timeout),      0);
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later, advance model.
    task automatic cycle(bit p1s, int p1c, bit p2s, int p2c, bit ng);
        bus.move_P1_i = p1s; bus.move_P1 = 4'(p1c);
        bus.move_P2_i = p2s; bus.move_P2 = 4'(p2c);
        bus.new_game  = ng;
        @(posedge clk);
        #1;
        model_step(p1s, p1c, p2s, p2c, ng);
        bus.move_P1_i = 1'b0; bus.move_P2_i = 1'b0; bus.new_game = 1'b0;
    endtask

    initial begin
        vec_t v;
        string tag;
        int pct;

        // T1 / T2
        tbl.push_back(V(1,4,0,0,0, 'h010,'h000,0,0,0,0,0));
        tbl.push_back(I(           'h010,'h000,1,0,0,0,0));
        tbl.push_back(V(0,0,1,4,0, 'h010,'h000,1,0,0,0,1));
        tbl.push_back(I(           'h010,'h000,1,0,0,0,0));
        tbl.push_back(V(0,0,1,9,0, 'h010,'h000,1,0,0,0,1));
        tbl.push_back(V(1,0,0,0,0, 'h010,'h000,1,0,0,0,1));
        tbl.push_back(V(0,0,0,0,1, 0,0,0,0,0,0,0));
        // T3: P1 top row win, later strobe ignored in DONE
        tbl.push_back(V(1,0,0,0,0, 'h001,'h000,0,0,0,0,0));
        tbl.push_back(I(           'h001,'h000,1,0,0,0,0));
        tbl.push_back(V(0,0,1,3,0, 'h001,'h008,1,0,0,0,0));
        tbl.push_back(I(           'h001,'h008,0,0,0,0,0));
        tbl.push_back(V(1,1,0,0,0, 'h003,'h008,0,0,0,0,0));
        tbl.push_back(I(           'h003,'h008,1,0,0,0,0));
        tbl.push_back(V(0,0,1,4,0, 'h003,'h018,1,0,0,0,0));
        tbl.push_back(I(           'h003,'h018,0,0,0,0,0));
        tbl.push_back(V(1,2,0,0,0, 'h007,'h018,0,0,0,0,0));
        tbl.push_back(I(           'h007,'h018,0,1,1,'h007,0));
        tbl.push_back(V(0,0,1,5,0, 'h007,'h018,0,1,1,'h007,0));
        tbl.push_back(V(0,0,0,0,1, 0,0,0,0,0,0,0));
        // T4: draw, with a strobe during EVAL and a double strobe in WAIT_P2
        tbl.push_back(V(1,0,0,0,0, 'h001,'h000,0,0,0,0,0));
        tbl.push_back(V(0,0,1,1,0, 'h001,'h000,1,0,0,0,1));
        tbl.push_back(V(0,0,1,1,0, 'h001,'h002,1,0,0,0,0));
        tbl.push_back(I(           'h001,'h002,0,0,0,0,0));
        tbl.push_back(V(1,2,0,0,0, 'h005,'h002,0,0,0,0,0));
        tbl.push_back(I(           'h005,'h002,1,0,0,0,0));
        tbl.push_back(V(1,6,1,4,0, 'h005,'h012,1,0,0,0,0));
        tbl.push_back(I(           'h005,'h012,0,0,0,0,0));
        tbl.push_back(V(1,3,0,0,0, 'h00D,'h012,0,0,0,0,0));
        tbl.push_back(I(           'h00D,'h012,1,0,0,0,0));
        tbl.push_back(V(0,0,1,5,0, 'h00D,'h032,1,0,0,0,0));
        tbl.push_back(I(           'h00D,'h032,0,0,0,0,0));
        tbl.push_back(V(1,7,0,0,0, 'h08D,'h032,0,0,0,0,0));
        tbl.push_back(I(           'h08D,'h032,1,0,0,0,0));
        tbl.push_back(V(0,0,1,6,0, 'h08D,'h072,1,0,0,0,0));
        tbl.push_back(I(           'h08D,'h072,0,0,0,0,0));
        tbl.push_back(V(1,8,0,0,0, 'h18D,'h072,0,0,0,0,0));
        tbl.push_back(I(           'h18D,'h072,0,1,3,0,0));
        tbl.push_back(V(0,0,0,0,1, 0,0,0,0,0,0,0));
        // Ninth move completing both diagonals: win, win_line is their OR
        tbl.push_back(V(1,0,0,0,0, 'h001,'h000,0,0,0,0,0));
        tbl.push_back(I(           'h001,'h000,1,0,0,0,0));
        tbl.push_back(V(0,0,1,0,0, 'h001,'h000,1,0,0,0,1));
        tbl.push_back(V(0,0,1,1,0, 'h001,'h002,1,0,0,0,0));
        tbl.push_back(I(           'h001,'h002,0,0,0,0,0));
        tbl.push_back(V(1,2,0,0,0, 'h005,'h002,0,0,0,0,0));
        tbl.push_back(I(           'h005,'h002,1,0,0,0,0));
        tbl.push_back(V(0,0,1,3,0, 'h005,'h00A,1,0,0,0,0));
        tbl.push_back(I(           'h005,'h00A,0,0,0,0,0));
        tbl.push_back(V(1,6,0,0,0, 'h045,'h00A,0,0,0,0,0));
        tbl.push_back(I(           'h045,'h00A,1,0,0,0,0));
        tbl.push_back(V(0,0,1,5,0, 'h045,'h02A,1,0,0,0,0));
        tbl.push_back(I(           'h045,'h02A,0,0,0,0,0));
        tbl.push_back(V(1,8,0,0,0, 'h145,'h02A,0,0,0,0,0));
        tbl.push_back(I(           'h145,'h02A,1,0,0,0,0));
        tbl.push_back(V(0,0,1,7,0, 'h145,'h0AA,1,0,0,0,0));
        tbl.push_back(I(           'h145,'h0AA,0,0,0,0,0));
        tbl.push_back(V(1,4,0,0,0, 'h155,'h0AA,0,0,0,0,0));
        tbl.push_back(I(           'h155,'h0AA,0,1,1,'h155,0));
        tbl.push_back(V(0,0,0,0,1, 0,0,0,0,0,0,0));
        // T5: new_game overrides a same-cycle legal P1 strobe
        tbl.push_back(V(1,0,0,0,0, 'h001,'h000,0,0,0,0,0));
        tbl.push_back(I(           'h001,'h000,1,0,0,0,0));
        tbl.push_back(V(0,0,1,4,0, 'h001,'h010,1,0,0,0,0));
        tbl.push_back(I(           'h001,'h010,0,0,0,0,0));
        tbl.push_back(V(1,8,0,0,1, 0,0,0,0,0,0,0));
        tbl.push_back(I(           0,0,0,0,0,0,0));

        bus.new_game = 1'b0; bus.move_P1_i = 1'b0; bus.move_P1 = 4'd0;
        bus.move_P2_i = 1'b0; bus.move_P2 = 4'd0;
        reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cycle(v.p1s != 0, v.p1c, v.p2s != 0, v.p2c, v.ng != 0);
            tag = $sformatf("row%0d", i);
            chk({tag, " board_P1"},  32'(bus.board_P1),     v.bp1);
            chk({tag, " board_P2"},  32'(bus.board_P2),     v.bp2);
            chk({tag, " turn"},      32'(bus.turn),         v.trn);
            chk({tag, " game_over"}, 32'(bus.game_over),    v.ovr);
            chk({tag, " winner"},    32'(bus.winner),       v.win);
            chk({tag, " win_line"},  32'(bus.win_line),     v.wl);
            chk({tag, " illegal"},   32'(bus.illegal_move), v.ill);
            chk({tag, " timeout"},   32'(bus.timeout),      0);
        end

        // T5: asynchronous reset in the EVAL cycle clears outputs without a clock edge
        cycle(1, 4, 0, 0, 0);
        chk("pre-reset board_P1", 32'(bus.board_P1), 'h010);
        reset_n = 1'b0;
        #1;
        check_zero("async reset");
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1, 4, 0, 0, 0);
        chk("post-reset move", 32'(bus.board_P1), 'h010);
        check_model("post-reset");

`ifdef MOVE_TIMEOUT_EN
        // T6: forfeit after c_TO idle cycles, then a legal move on the expiry cycle wins
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < c_TO - 1; i++) begin
            cycle(0, 0, 0, 0, 0);
            chk($sformatf("idle%0d timeout", i), 32'(bus.timeout), 0);
        end
        cycle(0, 0, 0, 0, 0);
        chk("expiry timeout", 32'(bus.timeout), 1);
        chk("expiry turn", 32'(bus.turn), 1);
        chk("expiry board_P1", 32'(bus.board_P1), 0);
        cycle(0, 0, 0, 0, 0);
        chk("after expiry timeout", 32'(bus.timeout), 0);
        for (int i = 0; i < c_TO - 2; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("expiry-cycle move timeout", 32'(bus.timeout), 0);
        chk("expiry-cycle move board_P2", 32'(bus.board_P2), 'h001);
        check_model("T6");
`endif

        // Randomized play with varying strobe density
        cycle(0, 0, 0, 0, 1);
        for (int blk = 0; blk < 20; blk++) begin
            pct = (blk % 3 == 0) ? 50 : ((blk % 3 == 1) ? 10 : 3);
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(99) < pct, $urandom_range(10),
                      $urandom_range(99) < pct, $urandom_range(10),
                      $urandom_range(79) == 0);
                check_model($sformatf("rand%0d.%0d", blk, i));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
